// File: rtl/decode_cycle.sv
// decode_cycle: ID stage of the 5-stage RV32I pipeline.
// Contains the 32x32 register file (x0 reads as zero), the control decoder,
// the immediate generator and the ID/EX pipeline register.
// Optional build macro: DECODE_RF_BYPASS_EN. When it is defined, a write and a
// read of the same register in one cycle returns the new value (write-first).
// When it is undefined, the read returns the old contents.
module decode_cycle #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            RegWriteW,
   input  logic [4:0]      RDW,
   input  logic [XLEN-1:0] ResultW,
   input  logic            FlushE,
   output logic [4:0]      Rs1D,
   output logic [4:0]      Rs2D,
   output logic            RegWriteE,
   output logic [1:0]      ResultSrcE,
   output logic            MemWriteE,
   output logic            JumpE,
   output logic            BranchE,
   output logic [2:0]      ALUControlE,
   output logic            ALUSrcE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [4:0]      RdE,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   logic [XLEN-1:0] regFile_r [NREGS];

   logic [6:0]      opcode_s;
   logic [2:0]      funct3_s;
   logic [4:0]      rd_s;
   logic            regWrite_s;
   logic [1:0]      resultSrc_s;
   logic            memWrite_s;
   logic            jump_s;
   logic            branch_s;
   logic            aluSrc_s;
   logic [2:0]      aluControl_s;
   logic [XLEN-1:0] immExt_s;
   logic [XLEN-1:0] rd1_s;
   logic [XLEN-1:0] rd2_s;

   assign opcode_s = InstrD[6:0];
   assign funct3_s = InstrD[14:12];
   assign rd_s     = InstrD[11:7];
   assign Rs1D     = InstrD[19:15];
   assign Rs2D     = InstrD[24:20];

   // Map funct3 to an ALU operation; sub only for R-type with funct7[5] set.
   function automatic logic [2:0] aluDecode(input logic [2:0] f3, input logic isR, input logic f7b5);
      logic [2:0] op;
      case (f3)
         3'b000:  op = (isR && f7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  op = ALU_SLT;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   // Register file read. x0 is forced to zero; the bypass, when built in,
   // forwards a same-cycle writeback to the matching read port.
   function automatic logic [XLEN-1:0] rfRead(input logic [4:0] idx, input logic [XLEN-1:0] stored,
                                              input logic wen, input logic [4:0] wIdx,
                                              input logic [XLEN-1:0] wData);
      logic [XLEN-1:0] val;
      if (idx == 5'd0) begin
         val = '0;
      end else begin
`ifdef DECODE_RF_BYPASS_EN
         if (wen && (wIdx == idx)) begin
            val = wData;
         end else begin
            val = stored;
         end
`else
         val = stored;
`endif
      end
      return val;
   endfunction

   // Main decoder: control signals and immediate selected by opcode.
   always_comb begin
      regWrite_s   = 1'b0;
      resultSrc_s  = 2'b00;
      memWrite_s   = 1'b0;
      jump_s       = 1'b0;
      branch_s     = 1'b0;
      aluSrc_s     = 1'b0;
      aluControl_s = ALU_ADD;
      immExt_s     = '0;
      case (opcode_s)
         OP_LW: begin
            regWrite_s  = 1'b1;
            aluSrc_s    = 1'b1;
            resultSrc_s = 2'b01;
            immExt_s    = {{20{InstrD[31]}}, InstrD[31:20]};
         end
         OP_SW: begin
            memWrite_s = 1'b1;
            aluSrc_s   = 1'b1;
            immExt_s   = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         end
         OP_R: begin
            regWrite_s   = 1'b1;
            aluControl_s = aluDecode(funct3_s, 1'b1, InstrD[30]);
         end
         OP_IALU: begin
            regWrite_s   = 1'b1;
            aluSrc_s     = 1'b1;
            aluControl_s = aluDecode(funct3_s, 1'b0, InstrD[30]);
            immExt_s     = {{20{InstrD[31]}}, InstrD[31:20]};
         end
         OP_BEQ: begin
            branch_s     = 1'b1;
            aluControl_s = ALU_SUB;
            immExt_s     = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
         end
         OP_JAL: begin
            regWrite_s  = 1'b1;
            jump_s      = 1'b1;
            resultSrc_s = 2'b10;
            immExt_s    = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
         end
         default: begin
            regWrite_s = 1'b0;
         end
      endcase
   end

   // Operand read ports feeding RD1E/RD2E.
   always_comb begin
      rd1_s = rfRead(Rs1D, regFile_r[Rs1D], RegWriteW, RDW, ResultW);
      rd2_s = rfRead(Rs2D, regFile_r[Rs2D], RegWriteW, RDW, ResultW);
   end

   // Register file write port; reset clears every entry, x0 is never written.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regFile_r[i] <= '0;
         end
      end else if (RegWriteW && (RDW != 5'd0)) begin
         regFile_r[RDW] <= ResultW;
      end
   end

   // ID/EX pipeline register; reset and flush both load an all-zero bubble.
   always_ff @(posedge clk) begin
      if (rst || FlushE) begin
         RegWriteE   <= 1'b0;
         ResultSrcE  <= 2'b00;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUControlE <= 3'b000;
         ALUSrcE     <= 1'b0;
         RD1E        <= '0;
         RD2E        <= '0;
         ImmExtE     <= '0;
         RdE         <= 5'd0;
         Rs1E        <= 5'd0;
         Rs2E        <= 5'd0;
         PCE         <= '0;
         PCPlus4E    <= '0;
      end else begin
         RegWriteE   <= regWrite_s;
         ResultSrcE  <= resultSrc_s;
         MemWriteE   <= memWrite_s;
         JumpE       <= jump_s;
         BranchE     <= branch_s;
         ALUControlE <= aluControl_s;
         ALUSrcE     <= aluSrc_s;
         RD1E        <= rd1_s;
         RD2E        <= rd2_s;
         ImmExtE     <= immExt_s;
         RdE         <= rd_s;
         Rs1E        <= Rs1D;
         Rs2E        <= Rs2D;
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
      end
   end

endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed self-checking bench for decode_cycle.
// Honours DECODE_RF_BYPASS_EN for the same-edge write/read expectation.
module tb_decode_cycle;

   logic        clk;
   logic        rst;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        RegWriteW;
   logic [4:0]  RDW;
   logic [31:0] ResultW;
   logic        FlushE;
   logic [4:0]  Rs1D;
   logic [4:0]  Rs2D;
   logic        RegWriteE;
   logic [1:0]  ResultSrcE;
   logic        MemWriteE;
   logic        JumpE;
   logic        BranchE;
   logic [2:0]  ALUControlE;
   logic        ALUSrcE;
   logic [31:0] RD1E;
   logic [31:0] RD2E;
   logic [31:0] ImmExtE;
   logic [4:0]  RdE;
   logic [4:0]  Rs1E;
   logic [4:0]  Rs2E;
   logic [31:0] PCE;
   logic [31:0] PCPlus4E;

   int checks = 0;
   int errors = 0;

   decode_cycle dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
      .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE),
      .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RdE(RdE),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .PCE(PCE), .PCPlus4E(PCPlus4E)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; InstrD = 32'h00500093; PCD = 32'h00000040; PCPlus4D = 32'h00000044;
      RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'h0; FlushE = 1'b0;
      step(); step();
      checks++; if (RegWriteE !== 1'b0) begin errors++; $display("FAIL rst_regwrite got %0h want 0", RegWriteE); end
      checks++; if (ALUSrcE !== 1'b0) begin errors++; $display("FAIL rst_alusrc got %0h want 0", ALUSrcE); end
      checks++; if (ImmExtE !== 32'h0) begin errors++; $display("FAIL rst_imm got %0h want 0", ImmExtE); end
      checks++; if (RdE !== 5'd0) begin errors++; $display("FAIL rst_rd got %0h want 0", RdE); end
      checks++; if (PCE !== 32'h0 || PCPlus4E !== 32'h0) begin errors++; $display("FAIL rst_pc got %0h/%0h want 0/0", PCE, PCPlus4E); end
      rst = 1'b0;
      step();
      checks++; if (RegWriteE !== 1'b1) begin errors++; $display("FAIL addi_regwrite got %0h want 1", RegWriteE); end
      checks++; if (ALUSrcE !== 1'b1) begin errors++; $display("FAIL addi_alusrc got %0h want 1", ALUSrcE); end
      checks++; if (ImmExtE !== 32'd5) begin errors++; $display("FAIL addi_imm got %0h want 5", ImmExtE); end
      checks++; if (RdE !== 5'd1) begin errors++; $display("FAIL addi_rd got %0h want 1", RdE); end
      checks++; if (ALUControlE !== 3'b000) begin errors++; $display("FAIL addi_alu got %0h want 0", ALUControlE); end
      checks++; if (PCE !== 32'h40 || PCPlus4E !== 32'h44) begin errors++; $display("FAIL addi_pc got %0h/%0h want 40/44", PCE, PCPlus4E); end
   endtask

   task automatic test_store();
      InstrD = 32'h0020A423; PCD = 32'h00000100; PCPlus4D = 32'h00000104;
      #1;
      checks++; if (Rs1D !== 5'd1 || Rs2D !== 5'd2) begin errors++; $display("FAIL sw_rsD got %0d/%0d want 1/2", Rs1D, Rs2D); end
      step();
      checks++; if (MemWriteE !== 1'b1) begin errors++; $display("FAIL sw_memwrite got %0h want 1", MemWriteE); end
      checks++; if (RegWriteE !== 1'b0) begin errors++; $display("FAIL sw_regwrite got %0h want 0", RegWriteE); end
      checks++; if (ImmExtE !== 32'd8) begin errors++; $display("FAIL sw_imm got %0h want 8", ImmExtE); end
      checks++; if (Rs1E !== 5'd1 || Rs2E !== 5'd2) begin errors++; $display("FAIL sw_rsE got %0d/%0d want 1/2", Rs1E, Rs2E); end
      checks++; if (ALUSrcE !== 1'b1) begin errors++; $display("FAIL sw_alusrc got %0h want 1", ALUSrcE); end
      checks++; if (PCE !== 32'h100) begin errors++; $display("FAIL sw_pc got %0h want 100", PCE); end
   endtask

   task automatic test_branch_jump();
      InstrD = 32'hFE208CE3;
      step();
      checks++; if (BranchE !== 1'b1) begin errors++; $display("FAIL beq_branch got %0h want 1", BranchE); end
      checks++; if (ALUControlE !== 3'b001) begin errors++; $display("FAIL beq_alu got %0h want 1", ALUControlE); end
      checks++; if (ImmExtE !== 32'hFFFFFFF8) begin errors++; $display("FAIL beq_imm got %0h want fffffff8", ImmExtE); end
      checks++; if (RegWriteE !== 1'b0 || JumpE !== 1'b0) begin errors++; $display("FAIL beq_ctl got %0h/%0h want 0/0", RegWriteE, JumpE); end
      InstrD = 32'h010000EF;
      step();
      checks++; if (JumpE !== 1'b1) begin errors++; $display("FAIL jal_jump got %0h want 1", JumpE); end
      checks++; if (ResultSrcE !== 2'b10) begin errors++; $display("FAIL jal_resultsrc got %0h want 2", ResultSrcE); end
      checks++; if (ImmExtE !== 32'd16) begin errors++; $display("FAIL jal_imm got %0h want 10", ImmExtE); end
      checks++; if (RegWriteE !== 1'b1 || RdE !== 5'd1) begin errors++; $display("FAIL jal_rd got %0h/%0d want 1/1", RegWriteE, RdE); end
      InstrD = 32'hFFFFFFFF;
      step();
      checks++; if (RegWriteE !== 1'b0 || MemWriteE !== 1'b0 || JumpE !== 1'b0) begin errors++; $display("FAIL illegal_ctl got %0h%0h%0h want 000", RegWriteE, MemWriteE, JumpE); end
      checks++; if (RdE !== 5'd31 || Rs1E !== 5'd31) begin errors++; $display("FAIL illegal_fields got %0d/%0d want 31/31", RdE, Rs1E); end
   endtask

   task automatic test_alu_decode();
      logic [31:0] instrs [7];
      logic [2:0]  expOp  [7];
      instrs[0] = 32'h00318233; expOp[0] = 3'b000; // add
      instrs[1] = 32'h40318233; expOp[1] = 3'b001; // sub
      instrs[2] = 32'h0031A233; expOp[2] = 3'b101; // slt
      instrs[3] = 32'h0031E233; expOp[3] = 3'b011; // or
      instrs[4] = 32'h0031F233; expOp[4] = 3'b010; // and
      instrs[5] = 32'h00319233; expOp[5] = 3'b000; // sll -> add
      instrs[6] = 32'h40018213; expOp[6] = 3'b000; // addi with imm[10] set, never sub
      for (int i = 0; i < 7; i++) begin
         InstrD = instrs[i];
         step();
         checks++; if (ALUControlE !== expOp[i]) begin errors++; $display("FAIL alu_decode[%0d] got %0h want %0h", i, ALUControlE, expOp[i]); end
      end
      checks++; if (ImmExtE !== 32'h400 || ALUSrcE !== 1'b1) begin errors++; $display("FAIL addi_imm400 got %0h/%0h want 400/1", ImmExtE, ALUSrcE); end
   endtask

   task automatic test_bypass();
      logic [31:0] expRd;
`ifdef DECODE_RF_BYPASS_EN
      expRd = 32'hDEADBEEF;
`else
      expRd = 32'h0;
`endif
      InstrD = 32'h00318233; RegWriteW = 1'b1; RDW = 5'd3; ResultW = 32'hDEADBEEF;
      step();
      RegWriteW = 1'b0;
      checks++; if (RD1E !== expRd || RD2E !== expRd) begin errors++; $display("FAIL same_edge got %0h/%0h want %0h", RD1E, RD2E, expRd); end
      step();
      checks++; if (RD1E !== 32'hDEADBEEF) begin errors++; $display("FAIL after_write got %0h want deadbeef", RD1E); end
   endtask

   task automatic test_regfile();
      InstrD = 32'h00000013; RegWriteW = 1'b1; RDW = 5'd7; ResultW = 32'hDEADBEEF;
      step();
      InstrD = 32'h00738233; RegWriteW = 1'b0;
      step();
      checks++; if (RD1E !== 32'hDEADBEEF || RD2E !== 32'hDEADBEEF) begin errors++; $display("FAIL x7_read got %0h/%0h want deadbeef", RD1E, RD2E); end
      checks++; if (RdE !== 5'd4 || Rs1E !== 5'd7) begin errors++; $display("FAIL x7_fields got %0d/%0d want 4/7", RdE, Rs1E); end
      InstrD = 32'h00000033; RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'h00001234;
      step();
      RegWriteW = 1'b0;
      checks++; if (RD1E !== 32'h0 || RD2E !== 32'h0) begin errors++; $display("FAIL x0_same_edge got %0h/%0h want 0", RD1E, RD2E); end
      step();
      checks++; if (RD1E !== 32'h0) begin errors++; $display("FAIL x0_read got %0h want 0", RD1E); end
   endtask

   task automatic test_flush();
      InstrD = 32'h00738233; PCD = 32'h200; PCPlus4D = 32'h204;
      FlushE = 1'b1; RegWriteW = 1'b1; RDW = 5'd8; ResultW = 32'h55AA55AA;
      step();
      checks++; if (RegWriteE !== 1'b0 || RD1E !== 32'h0 || RdE !== 5'd0) begin errors++; $display("FAIL flush_zero got %0h/%0h/%0d want 0/0/0", RegWriteE, RD1E, RdE); end
      checks++; if (PCE !== 32'h0 || Rs1E !== 5'd0 || ALUControlE !== 3'b000) begin errors++; $display("FAIL flush_pc got %0h/%0d/%0h want 0/0/0", PCE, Rs1E, ALUControlE); end
      FlushE = 1'b0; RegWriteW = 1'b0; InstrD = 32'h00040233;
      step();
      checks++; if (RD1E !== 32'h55AA55AA) begin errors++; $display("FAIL flush_write got %0h want 55aa55aa", RD1E); end
      InstrD = 32'h00738233; FlushE = 1'b1; rst = 1'b1; RegWriteW = 1'b1; RDW = 5'd9; ResultW = 32'h11111111;
      step();
      checks++; if (RegWriteE !== 1'b0 || RD1E !== 32'h0 || PCE !== 32'h0) begin errors++; $display("FAIL rst_flush got %0h/%0h/%0h want 0/0/0", RegWriteE, RD1E, PCE); end
      FlushE = 1'b0; rst = 1'b0; RegWriteW = 1'b0;
      step();
      checks++; if (RD1E !== 32'h0 || RegWriteE !== 1'b1) begin errors++; $display("FAIL rf_cleared got %0h/%0h want 0/1", RD1E, RegWriteE); end
      InstrD = 32'h00048233;
      step();
      checks++; if (RD1E !== 32'h0) begin errors++; $display("FAIL rst_beats_write got %0h want 0", RD1E); end
   endtask

   initial begin
      test_reset();
      test_store();
      test_branch_jump();
      test_alu_decode();
      test_bypass();
      test_regfile();
      test_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
ID stage of the 5-stage RV32I pipeline, directly downstream of fetch_cycle; consumes InstrD/PCD/PCPlus4D.
Contains 32x32 register file (x0 hardwired 0), main/ALU control decoder, immediate generator and ID/EX pipeline register.
Writeback port driven from W stage; FlushE from hazard unit inserts bubble into E.

Parameters:
XLEN, 32, datapath width
NREGS, 32, register file depth (x0..x31)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset; synchronous, active-high
InstrD  in  32  instruction from fetch_cycle
PCD  in  32  PC of InstrD
PCPlus4D  in  32  PCD+4
RegWriteW  in  1  writeback enable
RDW  in  5  writeback destination
ResultW  in  32  writeback data
FlushE  in  1  bubble ID/EX on next edge
Rs1D  out  5  InstrD[19:15], combinational, to hazard unit
Rs2D  out  5  InstrD[24:20], combinational, to hazard unit
RegWriteE  out  1  registered control
ResultSrcE  out  2  00 ALU, 01 mem, 10 PC+4
MemWriteE  out  1  store
JumpE  out  1  jal
BranchE  out  1  beq
ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ALUSrcE  out  1  1 = ImmExtE as operand B
RD1E  out  32  rs1 data
RD2E  out  32  rs2 data
ImmExtE  out  32  sign-extended immediate
RdE, Rs1E, Rs2E  out  5 each  register indices
PCE, PCPlus4E  out  32 each  PC values

Behaviour:
- Latency 1: all E outputs register decode of InstrD at rising edge.
- Reset (rst=1 at edge): every E output 0; all 32 regfile entries 0. Reset beats FlushE and writes.
- FlushE=1 (rst=0): every E output 0 next edge (bubble = all-zero controls); regfile write still occurs.
- Regfile: write on rising edge when RegWriteW=1 and RDW!=0; RDW=0 write ignored; reads combinational; x0 always 0.
- Decode by opcode[6:0]:
  0000011 lw: RegWrite=1, ImmSrc I, ALUSrc=1, ResultSrc=01, ALU add
  0100011 sw: MemWrite=1, ImmSrc S, ALUSrc=1, ALU add
  0110011 R: RegWrite=1, ALUSrc=0, ALU per funct3/funct7
  0010011 I-ALU: RegWrite=1, ImmSrc I, ALUSrc=1, ALU per funct3 (funct7 ignored, never sub)
  1100011 beq: Branch=1, ImmSrc B, ALU sub
  1101111 jal: RegWrite=1, Jump=1, ImmSrc J, ResultSrc=10
  other: all controls 0 (treated as bubble), data fields still registered.
- ALU decode: funct3 000 -> add, or sub if R-type and funct7[5]=1; 010 slt; 110 or; 111 and; other funct3 -> add.
- Immediates, sign bit InstrD[31]: I {[31:20]}; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; J {[31],[19:12],[20],[30:21],0}.
- Rs1E/Rs2E/RdE always from instruction fields regardless of format.
- Same-edge write and read of same register: see optional feature.

Optional Feature:
DECODE_RF_BYPASS_EN: defined -> read port returns ResultW when RegWriteW=1, RDW!=0, RDW==rs index (write-first, same-cycle bypass into RD1E/RD2E). Undefined -> read returns pre-write contents; hazard unit must cover the 3-cycle gap.

Test Plan:
- rst=1 two edges, InstrD=0x00500093 -> all E outputs 0; release rst, next edge: RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1, ALUControlE=000.
- InstrD=0x0020A423 (sw x2,8(x1)) -> MemWriteE=1, RegWriteE=0, ImmExtE=8, Rs1E=1, Rs2E=2.
- InstrD=0xFE208CE3 (beq x1,x2,-8) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8; InstrD=0x010000EF (jal x1,16) -> JumpE=1, ResultSrcE=10, ImmExtE=16.
- Write x3=0xDEADBEEF (RegWriteW=1,RDW=3) then InstrD=0x00318233 next cycle -> RD1E=RD2E=0xDEADBEEF; RDW=0 write of 0x1234 -> x0 reads 0.
- Same-edge write x3=0xDEADBEEF with InstrD=0x00318233 -> RD1E=0xDEADBEEF with DECODE_RF_BYPASS_EN, 0 without.
- FlushE=1 with valid add -> next edge all E outputs 0; FlushE and rst both 1 -> all 0 and regfile cleared.
